// File: rtl/vector_load_assembler.sv
// rtl/vector_load_assembler.sv - strided 4-lane vector gather into the vector register file
//
// Accepts one load request (base, stride, dest, mask). The block issues one
// memory read per enabled lane at base + lane*stride. It collects the in-order
// read responses into a lane buffer. It then drives a single one-cycle masked
// write of the buffer into the register file.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 load request handshake and fields (valid/ready)
//   mem_rd_*              memory read request channel (valid/ready, address)
//   mem_rsp_*             memory read response, in issue order, no backpressure
//   write_addr/vector/we  register-file write port, active only in WRITE
//   busy, done            status: not idle / one-cycle completion pulse

module vector_load_assembler #(
  parameter int LANES          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_base,
  input  logic [31:0]               req_stride,
  input  logic [REG_ADDR_WIDTH-1:0] req_dest,
  input  logic [LANES-1:0]          req_mask,
  output logic                      mem_rd_valid,
  input  logic                      mem_rd_ready,
  output logic [31:0]               mem_rd_addr,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]     write_vector [LANES],
  output logic [LANES-1:0]          we,
  output logic                      busy,
  output logic                      done
);

  localparam int LW = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [31:0]                 r_base;
  logic [31:0]                 r_stride;
  logic [REG_ADDR_WIDTH-1:0]   r_dest;
  logic [LANES-1:0]            r_mask;
  logic [LW-1:0]               r_issue_lane;
  logic [LW-1:0]               r_rsp_lane;
  logic [31:0]                 r_rd_addr;
  logic [DATA_WIDTH-1:0]       r_lanes [LANES];

  // Lowest enabled lane above cur (or at cur when incl is set).
  // The MSB of the result flags that such a lane exists.
  function automatic logic [LW:0] next_lane(input logic [LANES-1:0] mask,
                                            input logic [LW-1:0]    cur,
                                            input logic             incl);
    logic [LW:0] res;
    res = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        res = {1'b1, LW'(i)};
      end
    end
    return res;
  endfunction

  logic [LW:0] w_first;
  logic [LW:0] w_issue_nxt;
  logic [LW:0] w_rsp_nxt;
  logic        w_accept;
  logic        w_issue_fire;
  logic        w_issue_last;
  logic        w_rsp_take;
  logic        w_rsp_last;

  assign w_first      = next_lane(req_mask, '0, 1'b1);
  assign w_issue_nxt  = next_lane(r_mask, r_issue_lane, 1'b0);
  assign w_rsp_nxt    = next_lane(r_mask, r_rsp_lane, 1'b0);
  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_issue_fire = (r_state == S_ISSUE) && mem_rd_ready;
  assign w_issue_last = w_issue_fire && !w_issue_nxt[LW];
  // Responses are only meaningful while a gather is outstanding; anything
  // seen in IDLE or WRITE is dropped so the lane buffer can never overrun.
  assign w_rsp_take   = mem_rsp_valid && ((r_state == S_ISSUE) || (r_state == S_WAIT));
  assign w_rsp_last   = w_rsp_take && !w_rsp_nxt[LW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (req_mask != '0) ? S_ISSUE : S_WRITE;
        end
      end
      S_ISSUE: begin
        // A zero-latency response to the last issue completes the gather
        // in the same cycle, so the response check takes priority.
        if (w_rsp_last) begin
          w_state_nxt = S_WRITE;
        end else if (w_issue_last) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_rsp_last) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Issue and response lane pointers walk only the enabled lanes. They start
  // at the first set mask bit so no cycle is spent on disabled lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_stride     <= '0;
      r_dest       <= '0;
      r_mask       <= '0;
      r_issue_lane <= '0;
      r_rsp_lane   <= '0;
      r_rd_addr    <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_lanes[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_base       <= req_base;
        r_stride     <= req_stride;
        r_dest       <= req_dest;
        r_mask       <= req_mask;
        r_issue_lane <= w_first[LW-1:0];
        r_rsp_lane   <= w_first[LW-1:0];
        r_rd_addr    <= req_base + (32'(w_first[LW-1:0]) * req_stride);
        for (int i = 0; i < LANES; i++) begin
          r_lanes[i] <= '0;
        end
      end
      if (w_issue_fire && w_issue_nxt[LW]) begin
        r_issue_lane <= w_issue_nxt[LW-1:0];
        r_rd_addr    <= r_base + (32'(w_issue_nxt[LW-1:0]) * r_stride);
      end
      if (w_rsp_take) begin
        r_lanes[r_rsp_lane] <= mem_rsp_data;
        if (w_rsp_nxt[LW]) begin
          r_rsp_lane <= w_rsp_nxt[LW-1:0];
        end
      end
    end
  end

  // All outputs are decoded from registered state only.
  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_WRITE);
  assign mem_rd_valid = (r_state == S_ISSUE);
  assign mem_rd_addr  = (r_state == S_ISSUE) ? r_rd_addr : '0;
  assign we           = (r_state == S_WRITE) ? r_mask : '0;
  assign write_addr   = (r_state == S_WRITE) ? r_dest : '0;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      write_vector[i] = '0;
      if ((r_state == S_WRITE) && r_mask[i]) begin
        write_vector[i] = r_lanes[i];
      end
    end
  end

endmodule
